oflow_score_calc_engine: RTL and testbench

OFLOW_SCORE_CALC_ENGINE -- requirements
Module: oflow_score_calc_engine

---
 rtl/oflow_score_calc_pkg.sv | 37 +++
 rtl/oflow_score_abs_diff_sum.sv | 35 +++
 rtl/oflow_score_calc_engine.sv | 166 ++++++++++++++++
 tb/tb_oflow_score_calc_engine.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_score_calc_pkg.sv
// -----------------------------------------------------------------------------
// oflow_score_calc_pkg
// Shared definitions for the optical-flow score calculation engine:
//   - set-index width (overridable through the SET_LEN macro)
//   - default feature/score widths
//   - field positions of {x, y, w, h} inside a packed feature vector
//   - engine state encoding
// -----------------------------------------------------------------------------
`ifndef SET_LEN
`define SET_LEN 4
`endif

package oflow_score_calc_pkg;

  // Width of the set index presented on counter_of_sets / upper rd_addr bits.
  localparam int SET_LEN_W = `SET_LEN;

  // Default feature field width and the derived score width. Four fields of
  // FEAT_W bits summed need at most FEAT_W+2 bits, so no saturation is needed.
  localparam int FEAT_W_DEF  = 11;
  localparam int SCORE_W_DEF = FEAT_W_DEF + 2;

  // Packed feature vector is {x, y, w, h}; indices count fields from the LSB.
  localparam int NUM_FIELDS = 4;
  localparam int FIELD_X    = 3;
  localparam int FIELD_Y    = 2;
  localparam int FIELD_W    = 1;
  localparam int FIELD_H    = 0;

  typedef enum logic [1:0] {
    idle_st,
    req_st,
    wait_st,
    done_st
  } state_e;

endpackage

// File: rtl/oflow_score_abs_diff_sum.sv
// -----------------------------------------------------------------------------
// oflow_score_abs_diff_sum
// Purely combinational distance between two packed feature vectors:
//   score = |dx| + |dy| + |dw| + |dh|   (fields unsigned, full precision)
// Ports:
//   cur_features_i   4*FEAT_W  current-object features {x,y,w,h}
//   cand_features_i  4*FEAT_W  candidate features {x,y,w,h}
//   score_o          FEAT_W+2  sum of absolute field differences
// -----------------------------------------------------------------------------
module oflow_score_abs_diff_sum
  import oflow_score_calc_pkg::*;
#(
  parameter  int FEAT_W  = FEAT_W_DEF,
  localparam int SCORE_W = FEAT_W + 2
) (
  input  logic [4*FEAT_W-1:0] cur_features_i,
  input  logic [4*FEAT_W-1:0] cand_features_i,
  output logic [SCORE_W-1:0]  score_o
);

  logic [FEAT_W-1:0] diff [NUM_FIELDS];

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    logic [FEAT_W-1:0] a;
    logic [FEAT_W-1:0] b;
    assign a = cur_features_i[f*FEAT_W +: FEAT_W];
    assign b = cand_features_i[f*FEAT_W +: FEAT_W];
    // Subtract the smaller from the larger so the result never wraps.
    assign diff[f] = (a >= b) ? (a - b) : (b - a);
  end

  assign score_o = SCORE_W'(diff[FIELD_X]) + SCORE_W'(diff[FIELD_Y])
                 + SCORE_W'(diff[FIELD_W]) + SCORE_W'(diff[FIELD_H]);

endmodule

// File: rtl/oflow_score_calc_engine.sv
// -----------------------------------------------------------------------------
// oflow_score_calc_engine
// For one set of previous-frame candidates, reads each candidate's features
// from an external buffer, scores it against the current object and keeps the
// lowest score (lowest index wins ties). Reports the best match once per set.
// Ports:
//   clk, reset_N        clock (rising edge), async active-low reset
//   start_score_calc    one-cycle request; counter_of_sets, num_of_cand and
//                       cur_features are sampled with it
//   score_thresh        match threshold, sampled when the result is loaded
//   rd_req / rd_addr    one-cycle buffer read strobe, address {set, cand}
//   rd_valid / rd_data  candidate features returned by the buffer (latency>=1)
//   done_score_calc     one-cycle completion pulse
//   best_score/id/valid result, stable until the next completion
//   err_start_busy      sticky: start seen while not idle
// NUM_CAND_MAX must be at least 2.
// -----------------------------------------------------------------------------
module oflow_score_calc_engine
  import oflow_score_calc_pkg::*;
#(
  parameter  int NUM_CAND_MAX = 16,
  parameter  int FEAT_W       = FEAT_W_DEF,
  localparam int CAND_W       = $clog2(NUM_CAND_MAX),
  localparam int SCORE_W      = FEAT_W + 2
) (
  input  logic                        clk,
  input  logic                        reset_N,
  input  logic                        start_score_calc,
  input  logic [SET_LEN_W-1:0]        counter_of_sets,
  input  logic [CAND_W:0]             num_of_cand,
  input  logic [4*FEAT_W-1:0]         cur_features,
  input  logic [SCORE_W-1:0]          score_thresh,
  output logic                        rd_req,
  output logic [SET_LEN_W+CAND_W-1:0] rd_addr,
  input  logic                        rd_valid,
  input  logic [4*FEAT_W-1:0]         rd_data,
  output logic                        done_score_calc,
  output logic [SCORE_W-1:0]          best_score,
  output logic [CAND_W-1:0]           best_id,
  output logic                        best_valid,
  output logic                        err_start_busy
);

  state_e                 state_q;
  logic [SET_LEN_W-1:0]   set_idx_q;
  logic [CAND_W:0]        num_q;
  logic [4*FEAT_W-1:0]    cur_q;
  logic [CAND_W-1:0]      cand_cnt_q;
  logic [SCORE_W-1:0]     run_min_q;
  logic [CAND_W-1:0]      run_id_q;
  logic                   rd_req_q;
  logic                   done_q;
  logic [SCORE_W-1:0]     best_score_q;
  logic [CAND_W-1:0]      best_id_q;
  logic                   best_valid_q;
  logic                   err_q;

  logic [SCORE_W-1:0]     cand_score;
  logic [CAND_W:0]        num_d;
  logic                   last_cand;

  oflow_score_abs_diff_sum #(
    .FEAT_W (FEAT_W)
  ) u_abs_diff_sum (
    .cur_features_i  (cur_q),
    .cand_features_i (rd_data),
    .score_o         (cand_score)
  );

  // A count above NUM_CAND_MAX could never match the CAND_W-bit index and
  // would hang the read loop, so it is clipped on capture.
  assign num_d = (num_of_cand > (CAND_W+1)'(NUM_CAND_MAX))
               ? (CAND_W+1)'(NUM_CAND_MAX) : num_of_cand;

  assign last_cand = ({1'b0, cand_cnt_q} == (num_q - (CAND_W+1)'(1)));

  // Single FSM; rd_req and done are set on the transition edge so both come
  // straight from flops, never from inputs.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= idle_st;
      set_idx_q    <= '0;
      num_q        <= '0;
      cur_q        <= '0;
      cand_cnt_q   <= '0;
      run_min_q    <= '0;
      run_id_q     <= '0;
      rd_req_q     <= 1'b0;
      done_q       <= 1'b0;
      best_score_q <= '0;
      best_id_q    <= '0;
      best_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every branch
      // below reads the pre-edge register values regardless of order.
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;

      if (start_score_calc && (state_q != idle_st)) begin
        err_q <= 1'b1;
      end

      case (state_q)
        idle_st: begin
          if (start_score_calc) begin
            set_idx_q  <= counter_of_sets;
            num_q      <= num_d;
            cur_q      <= cur_features;
            cand_cnt_q <= '0;
            run_min_q  <= '1;
            run_id_q   <= '0;
            if (num_d == '0) begin
              state_q <= done_st;
            end else begin
              state_q  <= req_st;
              rd_req_q <= 1'b1;
            end
          end
        end

        req_st: begin
          state_q <= wait_st;
        end

        wait_st: begin
          if (rd_valid) begin
            // Strict compare: an equal later score keeps the earlier index.
            if (cand_score < run_min_q) begin
              run_min_q <= cand_score;
              run_id_q  <= cand_cnt_q;
            end
            if (last_cand) begin
              state_q <= done_st;
            end else begin
              cand_cnt_q <= cand_cnt_q + CAND_W'(1);
              state_q    <= req_st;
              rd_req_q   <= 1'b1;
            end
          end
        end

        done_st: begin
          done_q       <= 1'b1;
          best_score_q <= run_min_q;
          best_id_q    <= run_id_q;
          best_valid_q <= (num_q != '0) && (run_min_q <= score_thresh);
          state_q      <= idle_st;
        end

        default: begin
          state_q <= idle_st;
        end
      endcase
    end
  end

  assign rd_req          = rd_req_q;
  assign rd_addr         = {set_idx_q, cand_cnt_q};
  assign done_score_calc = done_q;
  assign best_score      = best_score_q;
  assign best_id         = best_id_q;
  assign best_valid      = best_valid_q;
  assign err_start_busy  = err_q;

endmodule

// File: tb/tb_oflow_score_calc_engine.sv
// -----------------------------------------------------------------------------
// tb_oflow_score_calc_engine
// Drives candidate sets into the engine with a behavioural buffer model of
// configurable read latency and compares the reported result against a
// reference computed directly from the scoring rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oflow_score_calc_engine;
  import oflow_score_calc_pkg::*;

  localparam int NUM_CAND_MAX = 16;
  localparam int FEAT_W       = FEAT_W_DEF;
  localparam int CAND_W       = $clog2(NUM_CAND_MAX);
  localparam int SCORE_W      = FEAT_W + 2;
  localparam int ADDR_W       = SET_LEN_W + CAND_W;
  localparam int FW4          = 4 * FEAT_W;
  localparam int FMAX         = (1 << FEAT_W) - 1;
  localparam int SMAX         = (1 << SCORE_W) - 1;

  logic                 clk;
  logic                 reset_N;
  logic                 start_score_calc;
  logic [SET_LEN_W-1:0] counter_of_sets;
  logic [CAND_W:0]      num_of_cand;
  logic [FW4-1:0]       cur_features;
  logic [SCORE_W-1:0]   score_thresh;
  logic                 rd_req;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_valid;
  logic [FW4-1:0]       rd_data;
  logic                 done_score_calc;
  logic [SCORE_W-1:0]   best_score;
  logic [CAND_W-1:0]    best_id;
  logic                 best_valid;
  logic                 err_start_busy;

  oflow_score_calc_engine #(
    .NUM_CAND_MAX (NUM_CAND_MAX),
    .FEAT_W       (FEAT_W)
  ) dut (
    .clk              (clk),
    .reset_N          (reset_N),
    .start_score_calc (start_score_calc),
    .counter_of_sets  (counter_of_sets),
    .num_of_cand      (num_of_cand),
    .cur_features     (cur_features),
    .score_thresh     (score_thresh),
    .rd_req           (rd_req),
    .rd_addr          (rd_addr),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .done_score_calc  (done_score_calc),
    .best_score       (best_score),
    .best_id          (best_id),
    .best_valid       (best_valid),
    .err_start_busy   (err_start_busy)
  );

  int errors = 0;
  int checks = 0;

  logic [FW4-1:0]    mem      [1 << ADDR_W];
  logic [FW4-1:0]    cand_buf [NUM_CAND_MAX];
  logic [ADDR_W-1:0] req_log  [$];
  int                lat      = 1;
  bit                spur_en  = 1'b0;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [FW4-1:0] pack(input int x, input int y, input int w, input int h);
    return {FEAT_W'(x), FEAT_W'(y), FEAT_W'(w), FEAT_W'(h)};
  endfunction

  function automatic int fld(input logic [FW4-1:0] f, input int idx);
    logic [FEAT_W-1:0] v;
    v = f[idx*FEAT_W +: FEAT_W];
    return int'(v);
  endfunction

  // Reference distance: plain integer arithmetic on the four fields.
  function automatic int ref_score(input logic [FW4-1:0] cur, input logic [FW4-1:0] cand);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = fld(cur, i) - fld(cand, i);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  function automatic int near(input int v);
    int r;
    r = v + int'($urandom_range(0, 40)) - 20;
    if (r < 0) r = 0;
    if (r > FMAX) r = FMAX;
    return r;
  endfunction

  // Buffer model: data for a strobe seen in cycle c appears in cycle c+lat.
  // With spur_en a bogus rd_valid (carrying a perfect match) is also driven in
  // the strobe cycle itself, which the engine must ignore.
  always @(negedge clk or negedge reset_N) begin
    if (!reset_N) begin
      rd_valid = 1'b0;
      pend_cnt = 0;
    end else begin
      rd_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[pend_addr];
        end
      end
      if (rd_req) begin
        req_log.push_back(rd_addr);
        pend_addr = rd_addr;
        pend_cnt  = lat;
        if (spur_en) begin
          rd_valid = 1'b1;
          rd_data  = cur_features;
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "/rd_req"},     32'(rd_req), 0);
    check({name, "/rd_addr"},    32'(rd_addr), 0);
    check({name, "/done"},       32'(done_score_calc), 0);
    check({name, "/best_score"}, 32'(best_score), 0);
    check({name, "/best_id"},    32'(best_id), 0);
    check({name, "/best_valid"}, 32'(best_valid), 0);
    check({name, "/err"},        32'(err_start_busy), 0);
  endtask

  task automatic release_reset(input string name);
    @(negedge clk);
    reset_N = 1'b1;
    @(posedge clk);
    #1;
    check({name, "/no_done_after_rel"}, 32'(done_score_calc), 0);
    check({name, "/no_req_after_rel"},  32'(rd_req), 0);
  endtask

  // Runs one set. thresh<0 picks a threshold near the expected best score.
  // rst_cyc>=0 aborts the set with a reset in that cycle.
  task automatic run_set(input string name, input int set, input int n, input int l,
                         input int thresh, input logic [FW4-1:0] cur, input bit spur,
                         input bit err_pulse, input int rst_cyc);
    int exp_best, exp_id, exp_cyc, cyc, th;
    bit exp_valid;
    logic [ADDR_W-1:0] a;
    exp_best = SMAX;
    exp_id   = 0;
    for (int i = 0; i < n; i++) begin
      int s;
      a      = ADDR_W'(set * NUM_CAND_MAX + i);
      mem[a] = cand_buf[i];
      s      = ref_score(cur, cand_buf[i]);
      if (s < exp_best) begin
        exp_best = s;
        exp_id   = i;
      end
    end
    th = thresh;
    if (th < 0) begin
      th = exp_best + int'($urandom_range(0, 6)) - 3;
      if (th < 0) th = 0;
      if (th > SMAX) th = SMAX;
    end
    exp_valid = (n != 0) && (exp_best <= th);
    exp_cyc   = n * (l + 1) + 1;

    @(negedge clk);
    lat              = l;
    spur_en          = spur;
    req_log.delete();
    counter_of_sets  = SET_LEN_W'(set);
    num_of_cand      = (CAND_W+1)'(n);
    cur_features     = cur;
    score_thresh     = SCORE_W'(th);
    start_score_calc = 1'b1;
    @(posedge clk);
    #1;
    start_score_calc = 1'b0;
    cyc = 0;
    while (cyc < exp_cyc + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (err_pulse && cyc == 1) begin
        check({name, "/err_before"}, 32'(err_start_busy), 0);
        start_score_calc = 1'b1;
        counter_of_sets  = ~SET_LEN_W'(set);
        num_of_cand      = (CAND_W+1)'(1);
        cur_features     = ~cur;
      end
      if (err_pulse && cyc == 2) start_score_calc = 1'b0;
      if (cyc == rst_cyc) begin
        reset_N = 1'b0;
        #1;
        check_all_zero({name, "/mid_reset"});
        release_reset(name);
        return;
      end
      if (done_score_calc) break;
    end
    check({name, "/done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, "/best_score"}, 32'(best_score), 32'(exp_best));
    check({name, "/best_id"},    32'(best_id), 32'(exp_id));
    check({name, "/best_valid"}, 32'(best_valid), 32'(exp_valid));
    check({name, "/num_reads"},  32'(req_log.size()), 32'(n));
    for (int i = 0; i < n && i < req_log.size(); i++) begin
      check({name, "/rd_addr"}, 32'(req_log[i]), 32'(set * NUM_CAND_MAX + i));
    end
    if (err_pulse) check({name, "/err_set"}, 32'(err_start_busy), 1);
    @(posedge clk);
    #1;
    check({name, "/done_one_cycle"}, 32'(done_score_calc), 0);
    if (cyc != exp_cyc) begin
      // Recover from a hung or misbehaving run so later sets are meaningful.
      reset_N = 1'b0;
      #1;
      release_reset({name, "/recover"});
    end
  endtask

  initial begin
    logic [FW4-1:0] cur;
    reset_N          = 1'b0;
    start_score_calc = 1'b0;
    counter_of_sets  = '0;
    num_of_cand      = '0;
    cur_features     = '0;
    score_thresh     = '0;
    rd_data          = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    release_reset("reset");

    // Three candidates, exact match last.
    cur = pack(10, 10, 5, 5);
    cand_buf[0] = pack(20, 10, 5, 5);
    cand_buf[1] = pack(11, 9, 5, 5);
    cand_buf[2] = pack(10, 10, 5, 5);
    run_set("basic3", 0, 3, 1, 4, cur, 1'b0, 1'b0, -1);

    // Tie on score 7, above threshold.
    cand_buf[0] = pack(17, 10, 5, 5);
    cand_buf[1] = pack(10, 10, 5, 12);
    run_set("tie", 1, 2, 1, 3, cur, 1'b0, 1'b0, -1);

    run_set("empty", 2, 0, 1, 100, cur, 1'b0, 1'b0, -1);

    // Long latency with bogus rd_valid in every strobe cycle.
    cand_buf[0] = pack(30, 12, 5, 5);
    cand_buf[1] = pack(12, 12, 6, 5);
    cand_buf[2] = pack(9, 10, 5, 9);
    cand_buf[3] = pack(40, 40, 40, 40);
    run_set("lat5_spur", 3, 4, 5, 10, cur, 1'b1, 1'b0, -1);

    // Start re-pulsed while waiting on a read.
    cand_buf[0] = pack(20, 10, 5, 5);
    cand_buf[1] = pack(11, 9, 5, 5);
    cand_buf[2] = pack(10, 10, 5, 5);
    run_set("busy_start", 4, 3, 1, 4, cur, 1'b0, 1'b1, -1);

    cand_buf[0] = pack(17, 10, 5, 5);
    cand_buf[1] = pack(10, 10, 5, 12);
    run_set("after_err", 6, 2, 1, 3, cur, 1'b0, 1'b0, -1);
    check("err_sticky", 32'(err_start_busy), 1);

    // Reset while in wait_st of the second candidate, then a normal set.
    for (int i = 0; i < 4; i++) cand_buf[i] = pack(i, 3, 7, 1);
    run_set("mid_reset", 5, 4, 1, 50, cur, 1'b0, 1'b0, 3);
    run_set("post_reset", 5, 4, 1, 50, cur, 1'b0, 1'b0, -1);

    // Full set, all at maximum distance: ties everywhere, threshold equal.
    for (int i = 0; i < NUM_CAND_MAX; i++) cand_buf[i] = pack(0, 0, 0, 0);
    run_set("max_dist", 15, NUM_CAND_MAX, 1, 4 * FMAX, pack(FMAX, FMAX, FMAX, FMAX),
            1'b0, 1'b0, -1);

    // Full set, unique best at the highest index.
    for (int i = 0; i < NUM_CAND_MAX; i++) cand_buf[i] = pack(100 + i, 50, 50, 50);
    cand_buf[NUM_CAND_MAX-1] = pack(60, 50, 50, 50);
    run_set("best_last", 7, NUM_CAND_MAX, 2, 0, pack(60, 50, 50, 50), 1'b0, 1'b0, -1);

    for (int t = 0; t < 25; t++) begin
      int n, l, x, y, w, h;
      bit spur;
      n = int'($urandom_range(0, NUM_CAND_MAX));
      l = int'($urandom_range(1, 4));
      x = int'($urandom_range(0, FMAX));
      y = int'($urandom_range(0, FMAX));
      w = int'($urandom_range(0, FMAX));
      h = int'($urandom_range(0, FMAX));
      cur = pack(x, y, w, h);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: cand_buf[i] = pack(int'($urandom_range(0, FMAX)), int'($urandom_range(0, FMAX)),
                                int'($urandom_range(0, FMAX)), int'($urandom_range(0, FMAX)));
          1: cand_buf[i] = (i > 0) ? cand_buf[i-1] : cur;
          default: cand_buf[i] = pack(near(x), near(y), near(w), near(h));
        endcase
      end
      spur = (l >= 2) && ($urandom_range(0, 1) == 1);
      run_set($sformatf("rand%0d", t), int'($urandom_range(0, (1 << SET_LEN_W) - 1)),
              n, l, -1, cur, spur, 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
